// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed data memory responder with fixed wait states for the MEM stage
module data_mem_responder #(
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(WAIT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               op_wr;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic [31:0]        mem [DEPTH];

    logic               req;
    logic [IDX_W-1:0]   in_idx;
    logic               entering_done;
    logic               acc_wr;
    logic [IDX_W-1:0]   acc_idx;
    logic [31:0]        acc_wdata;

    assign req    = rd_en | wr_en;
    // Out-of-range addresses simply alias: the subtraction wraps and the index truncates.
    assign in_idx = IDX_W'((address - 32'(BASE_ADDR)) >> 2);
    assign ready  = (state == IDLE && !req) || state == DONE;

    // With a single wait state the access happens straight out of IDLE, so it uses live inputs.
    always_comb begin
        entering_done = 1'b0;
        acc_wr        = op_wr;
        acc_idx       = idx_q;
        acc_wdata     = wdata_q;
        if (state == IDLE) begin
            entering_done = req && (WAIT_CYCLES == 1);
            acc_wr        = wr_en;
            acc_idx       = in_idx;
            acc_wdata     = wdata;
        end else if (state == WAIT) begin
            entering_done = (cnt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && entering_done && acc_wr) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            rdata <= '0;
        end else begin
            if (entering_done && !acc_wr) begin
                rdata <= mem[acc_idx];
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        op_wr   <= wr_en;
                        idx_q   <= in_idx;
                        wdata_q <= wdata;
                        if (WAIT_CYCLES == 1) begin
                            state <= DONE;
                        end else begin
                            cnt   <= CNT_W'(WAIT_CYCLES - 2);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
